// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths, FSM state and requester-ID types for the multiplier scheduler
package mult_pkg;

   localparam int OP_W  = 8;
   localparam int RES_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_DELIVER = 2'd3
   } state_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

endpackage

// File: rtl/mult_sched_if.sv
// rtl/mult_sched_if.sv - requester A/B handshakes and shared-multiplier bus of the scheduler
interface mult_sched_if;
   import mult_pkg::*;

   logic                    a_valid;
   logic                    a_ready;
   logic signed [OP_W-1:0]  a_mc;
   logic signed [OP_W-1:0]  a_mp;
   logic                    a_done;
   logic signed [RES_W-1:0] a_result;
   logic                    a_err;

   logic                    b_valid;
   logic                    b_ready;
   logic signed [OP_W-1:0]  b_mc;
   logic signed [OP_W-1:0]  b_mp;
   logic                    b_done;
   logic signed [RES_W-1:0] b_result;
   logic                    b_err;

   logic                    mul_valid;
   logic signed [OP_W-1:0]  mul_mc;
   logic signed [OP_W-1:0]  mul_mp;
   logic                    mul_done;
   logic signed [RES_W-1:0] mul_result;

   logic                    busy;

   // Scheduler side.
   modport slave (
      input  a_valid, a_mc, a_mp, b_valid, b_mc, b_mp, mul_done, mul_result,
      output a_ready, a_done, a_result, a_err,
      output b_ready, b_done, b_result, b_err,
      output mul_valid, mul_mc, mul_mp, busy
   );

   // Requesters plus multiplier side.
   modport master (
      output a_valid, a_mc, a_mp, b_valid, b_mc, b_mp, mul_done, mul_result,
      input  a_ready, a_done, a_result, a_err,
      input  b_ready, b_done, b_result, b_err,
      input  mul_valid, mul_mc, mul_mp, busy
   );

endinterface

// File: rtl/mult_rr_arb.sv
// rtl/mult_rr_arb.sv - two-requester round-robin grant; ptr names the requester favoured on a tie
module mult_rr_arb
   import mult_pkg::*;
(
   input  logic       a_valid,
   input  logic       b_valid,
   input  req_id_t    ptr,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (a_valid && (!b_valid || ptr == REQ_A)) begin
         grant = 2'b01;
      end else if (b_valid) begin
         grant = 2'b10;
      end
   end

endmodule

// File: rtl/mult_sched.sv
// rtl/mult_sched.sv - arbitrates requesters A/B onto one shared multiplier and returns results
// Optional WAIT-state abort timer enabled by defining MULT_SCHED_TIMEOUT_EN.
module mult_sched
   import mult_pkg::*;
#(
   parameter int TIMEOUT_CYC = 15
) (
   input  logic        clk,
   input  logic        rst,
   mult_sched_if.slave bus
);

   if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 15) begin : g_bad_timeout
      $error("mult_sched: TIMEOUT_CYC must be within 2..15");
   end

   state_t                  state;
   state_t                  state_nxt;
   req_id_t                 ptr;
   req_id_t                 owner;
   logic [1:0]              grant;
   logic                    handshake;
   logic                    capture;
   logic                    timeout_hit;
   logic signed [OP_W-1:0]  mc_q;
   logic signed [OP_W-1:0]  mp_q;
   logic signed [RES_W-1:0] a_result_q;
   logic signed [RES_W-1:0] b_result_q;

   mult_rr_arb u_arb (
      .a_valid (bus.a_valid),
      .b_valid (bus.b_valid),
      .ptr     (ptr),
      .grant   (grant)
   );

   assign handshake = (state == ST_IDLE) && (grant != 2'b00);
   assign capture   = (state == ST_WAIT) && (bus.mul_done || timeout_hit);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (handshake) state_nxt = ST_ISSUE;
         ST_ISSUE:   state_nxt = ST_WAIT;
         ST_WAIT:    if (capture) state_nxt = ST_DELIVER;
         ST_DELIVER: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.a_ready   = (state == ST_IDLE) && grant[0];
      bus.b_ready   = (state == ST_IDLE) && grant[1];
      bus.mul_valid = (state == ST_ISSUE);
      bus.a_done    = (state == ST_DELIVER) && (owner == REQ_A);
      bus.b_done    = (state == ST_DELIVER) && (owner == REQ_B);
      bus.busy      = (state != ST_IDLE);
   end

   // Operands and owner are frozen at the handshake, so a requester may drop valid afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr        <= REQ_A;
         owner      <= REQ_A;
         mc_q       <= '0;
         mp_q       <= '0;
         a_result_q <= '0;
         b_result_q <= '0;
      end else begin
         if (handshake) begin
            owner <= grant[1] ? REQ_B : REQ_A;
            ptr   <= grant[1] ? REQ_A : REQ_B;
            mc_q  <= grant[1] ? bus.b_mc : bus.a_mc;
            mp_q  <= grant[1] ? bus.b_mp : bus.a_mp;
         end
         if (capture) begin
            if (owner == REQ_A) begin
               a_result_q <= bus.mul_done ? bus.mul_result : '0;
            end else begin
               b_result_q <= bus.mul_done ? bus.mul_result : '0;
            end
         end
      end
   end

   assign bus.mul_mc   = mc_q;
   assign bus.mul_mp   = mp_q;
   assign bus.a_result = a_result_q;
   assign bus.b_result = b_result_q;

`ifdef MULT_SCHED_TIMEOUT_EN
   logic [3:0] wait_cnt;
   logic       a_err_q;
   logic       b_err_q;

   always_ff @(posedge clk) begin
      if (rst || state != ST_WAIT) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // A mul_done in the final WAIT cycle beats the abort.
   assign timeout_hit = (state == ST_WAIT) && !bus.mul_done
                        && (wait_cnt == 4'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         a_err_q <= 1'b0;
         b_err_q <= 1'b0;
      end else if (capture) begin
         if (owner == REQ_A) begin
            a_err_q <= !bus.mul_done;
         end else begin
            b_err_q <= !bus.mul_done;
         end
      end
   end

   assign bus.a_err = a_err_q;
   assign bus.b_err = b_err_q;
`else
   assign timeout_hit = 1'b0;
   assign bus.a_err   = 1'b0;
   assign bus.b_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mult_sched.sv
// tb/tb_mult_sched.sv - self-checking bench for mult_sched with a behavioural multiplier model
module tb_mult_sched;
   import mult_pkg::*;

   logic clk;
   logic rst;
   mult_sched_if bus();

   mult_sched #(.TIMEOUT_CYC(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // multiplier model + event counters
   int  resp_cnt  = 0;
   int  resp_lat  = 8;
   bit  resp_en   = 1'b1;
   bit  resp_rand = 1'b0;
   bit  inject_done = 1'b0;
   logic signed [15:0] inject_val = 16'sd0;
   logic signed [15:0] resp_prod  = 16'sd0;
   int  ad_cnt = 0, bd_cnt = 0, mv_cnt = 0, both_rdy = 0;
   int  ad_cyc = 0, bd_cyc = 0, mv_cyc = 0;
   logic [7:0] mv_mc = 8'h0, mv_mp = 8'h0;

   initial begin
      bus.mul_done   = 1'b0;
      bus.mul_result = 16'sd0;
      forever begin
         @(negedge clk);
         bus.mul_done = 1'b0;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               bus.mul_done   = 1'b1;
               bus.mul_result = resp_prod;
            end
         end
         if (inject_done) begin
            bus.mul_done   = 1'b1;
            bus.mul_result = inject_val;
            inject_done    = 1'b0;
         end
         if (bus.mul_valid === 1'b1) begin
            mv_cyc = cyc;
            mv_mc  = bus.mul_mc;
            mv_mp  = bus.mul_mp;
            mv_cnt++;
            if (resp_en) begin
               resp_cnt  = resp_rand ? int'($urandom_range(1, 6)) : resp_lat;
               resp_prod = 16'(bus.mul_mc) * 16'(bus.mul_mp);
            end
         end
         if (bus.a_done === 1'b1) begin ad_cnt++; ad_cyc = cyc; end
         if (bus.b_done === 1'b1) begin bd_cnt++; bd_cyc = cyc; end
         if (bus.a_ready === 1'b1 && bus.b_ready === 1'b1) both_rdy++;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_mv(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         sample();
         if (bus.mul_valid === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_a_done(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         sample();
         if (bus.a_done === 1'b1) ok = 1'b1;
      end
   endtask

   // records of a dual-requester run
   int ord_q[$], hs_q[$], mvq[$], rec_id[$], rec_cyc[$];
   logic signed [15:0] rec_res[$], rec_oth[$], rec_exp[$];
   logic rec_err[$];

   task automatic drive_dual(input int n, input bit b_fixed, output bit timed_out);
      int hs = 0, dn = 0, budget = 0;
      bit hs_a, hs_b;
      logic signed [15:0] fly_a = 16'sd0, fly_b = 16'sd0;
      ord_q.delete(); hs_q.delete(); mvq.delete(); rec_id.delete(); rec_cyc.delete();
      rec_res.delete(); rec_oth.delete(); rec_exp.delete(); rec_err.delete();
      tick();
      bus.a_valid = 1'b1;
      bus.a_mc = 8'($urandom);
      bus.a_mp = 8'($urandom);
      bus.b_valid = 1'b1;
      bus.b_mc = b_fixed ? -8'sd128 : 8'($urandom);
      bus.b_mp = b_fixed ? -8'sd128 : 8'($urandom);
      while (dn < n && budget < 500) begin
         sample();
         budget++;
         hs_a = bus.a_valid && (bus.a_ready === 1'b1);
         hs_b = bus.b_valid && (bus.b_ready === 1'b1);
         if (bus.mul_valid === 1'b1) mvq.push_back(cyc);
         if (hs_a) begin
            fly_a = 16'(bus.a_mc) * 16'(bus.a_mp);
            ord_q.push_back(0); hs_q.push_back(cyc); hs++;
         end
         if (hs_b) begin
            fly_b = 16'(bus.b_mc) * 16'(bus.b_mp);
            ord_q.push_back(1); hs_q.push_back(cyc); hs++;
         end
         if (bus.a_done === 1'b1) begin
            rec_id.push_back(0); rec_res.push_back(bus.a_result); rec_oth.push_back(bus.b_result);
            rec_exp.push_back(fly_a); rec_cyc.push_back(cyc); rec_err.push_back(bus.a_err); dn++;
         end
         if (bus.b_done === 1'b1) begin
            rec_id.push_back(1); rec_res.push_back(bus.b_result); rec_oth.push_back(bus.a_result);
            rec_exp.push_back(fly_b); rec_cyc.push_back(cyc); rec_err.push_back(bus.b_err); dn++;
         end
         tick();
         if (hs_a) begin
            bus.a_mc = 8'($urandom);
            bus.a_mp = 8'($urandom);
         end
         if (hs_b && !b_fixed) begin
            bus.b_mc = 8'($urandom);
            bus.b_mp = 8'($urandom);
         end
         if (hs >= n) begin
            bus.a_valid = 1'b0;
            bus.b_valid = 1'b0;
         end
      end
      timed_out = (dn < n);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      bus.a_mc = 8'sd0; bus.a_mp = 8'sd0; bus.b_mc = 8'sd0; bus.b_mp = 8'sd0;
      repeat (3) tick();
      sample();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.mul_valid !== 1'b0) begin errors++; $display("FAIL reset_mul_valid: got %b want 0", bus.mul_valid); end
      checks++; if ({bus.a_done, bus.b_done} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", {bus.a_done, bus.b_done}); end
      checks++; if ({bus.a_err, bus.b_err} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", {bus.a_err, bus.b_err}); end
      checks++; if (bus.a_result !== 16'sd0) begin errors++; $display("FAIL reset_a_result: got %h want 0000", bus.a_result); end
      checks++; if (bus.b_result !== 16'sd0) begin errors++; $display("FAIL reset_b_result: got %h want 0000", bus.b_result); end
      checks++; if ({bus.mul_mc, bus.mul_mp} !== 16'h0000) begin errors++; $display("FAIL reset_mul_ops: got %h want 0000", {bus.mul_mc, bus.mul_mp}); end
      checks++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {bus.a_ready, bus.b_ready}); end
      rst = 1'b0;
   endtask

   task automatic test_a_alone();
      int hs_cyc, bd0;
      bit ok;
      do_reset();
      resp_en = 1'b1; resp_rand = 1'b0; resp_lat = 8;
      bd0 = bd_cnt;
      tick();
      bus.a_valid = 1'b1; bus.a_mc = 8'sd7; bus.a_mp = -8'sd3; bus.b_valid = 1'b0;
      sample();
      hs_cyc = cyc;
      checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL alone_a_ready: got %b want 1", bus.a_ready); end
      tick();
      bus.a_valid = 1'b0; bus.a_mc = 8'sh55; bus.a_mp = 8'sh11;
      wait_a_done(30, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL alone_done_timeout: got no a_done within 30 cycles"); end
      checks++; if (mv_cyc !== hs_cyc + 1) begin errors++; $display("FAIL alone_issue_latency: got %0d want %0d", mv_cyc, hs_cyc + 1); end
      checks++; if ({mv_mc, mv_mp} !== 16'h07FD) begin errors++; $display("FAIL alone_mul_ops: got %h want 07fd", {mv_mc, mv_mp}); end
      checks++; if (ad_cyc !== mv_cyc + 9) begin errors++; $display("FAIL alone_done_latency: got %0d want %0d", ad_cyc, mv_cyc + 9); end
      checks++; if (bus.a_result !== 16'hFFEB) begin errors++; $display("FAIL alone_a_result: got %h want ffeb", bus.a_result); end
      checks++; if (bus.a_err !== 1'b0) begin errors++; $display("FAIL alone_a_err: got %b want 0", bus.a_err); end
      checks++; if (bd_cnt !== bd0) begin errors++; $display("FAIL alone_b_done: got %0d pulses want 0", bd_cnt - bd0); end
      sample();
      checks++; if ({bus.a_done, bus.busy} !== 2'b00) begin errors++; $display("FAIL alone_after: got done,busy=%b want 00", {bus.a_done, bus.busy}); end
      checks++; if (bus.a_result !== 16'hFFEB) begin errors++; $display("FAIL alone_result_hold: got %h want ffeb", bus.a_result); end
   endtask

   task automatic test_both_valid();
      bit to;
      do_reset();
      resp_en = 1'b1; resp_rand = 1'b1;
      drive_dual(2, 1'b0, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL both_timeout: got %0d completions want 2", rec_id.size()); end
      checks++; if (ord_q[0] !== 0 || ord_q[1] !== 1) begin errors++; $display("FAIL both_grant_order: got %0d,%0d want 0,1", ord_q[0], ord_q[1]); end
      checks++; if (mvq[0] !== hs_q[0] + 1) begin errors++; $display("FAIL both_a_issue: got %0d want %0d", mvq[0], hs_q[0] + 1); end
      checks++; if (mvq[1] !== rec_cyc[0] + 2) begin errors++; $display("FAIL both_b_issue: got %0d want %0d", mvq[1], rec_cyc[0] + 2); end
      for (int i = 0; i < 2; i++) begin
         checks++; if (rec_res[i] !== rec_exp[i] || rec_id[i] !== i || rec_err[i] !== 1'b0) begin
            errors++; $display("FAIL both_result[%0d]: got id=%0d res=%h err=%b want id=%0d res=%h err=0", i, rec_id[i], rec_res[i], rec_err[i], i, rec_exp[i]);
         end
      end
      checks++; if (both_rdy !== 0) begin errors++; $display("FAIL both_ready_exclusive: got %0d cycles with both readies want 0", both_rdy); end
   endtask

   task automatic test_back_to_back();
      bit to;
      do_reset();
      resp_en = 1'b1; resp_rand = 1'b1;
      drive_dual(4, 1'b1, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL b2b_timeout: got %0d completions want 4", rec_id.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (rec_id[i] !== i % 2 || rec_res[i] !== rec_exp[i]) begin
            errors++; $display("FAIL b2b_txn[%0d]: got id=%0d res=%h want id=%0d res=%h", i, rec_id[i], rec_res[i], i % 2, rec_exp[i]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         checks++; if (mvq[i + 1] !== rec_cyc[i] + 2) begin errors++; $display("FAIL b2b_issue[%0d]: got %0d want %0d", i + 1, mvq[i + 1], rec_cyc[i] + 2); end
      end
      checks++; if (rec_oth[2] !== 16'h4000) begin errors++; $display("FAIL b2b_b_retained: got %h want 4000", rec_oth[2]); end
      sample();
      checks++; if (bus.b_result !== 16'h4000) begin errors++; $display("FAIL b2b_b_final: got %h want 4000", bus.b_result); end
   endtask

   task automatic test_idle_done();
      logic signed [15:0] ar, br;
      int na, nb, nm;
      repeat (3) tick();
      ar = bus.a_result; br = bus.b_result;
      na = ad_cnt; nb = bd_cnt; nm = mv_cnt;
      inject_val = 16'($urandom);
      inject_done = 1'b1;
      repeat (6) sample();
      checks++; if (bus.a_result !== ar || bus.b_result !== br) begin
         errors++; $display("FAIL idle_done_results: got %h/%h want %h/%h", bus.a_result, bus.b_result, ar, br);
      end
      checks++; if (ad_cnt !== na || bd_cnt !== nb || mv_cnt !== nm) begin
         errors++; $display("FAIL idle_done_pulses: got %0d/%0d/%0d extra want 0/0/0", ad_cnt - na, bd_cnt - nb, mv_cnt - nm);
      end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_done_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      int na, nb, nm;
      bit ok;
      do_reset();
      resp_en = 1'b0;
      tick();
      bus.a_valid = 1'b1; bus.a_mc = 8'($urandom); bus.a_mp = 8'($urandom);
      wait_mv(10, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_issue: got no mul_valid within 10 cycles"); end
      tick();
      bus.a_valid = 1'b0;
      repeat (3) tick();
      na = ad_cnt; nb = bd_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      nm = mv_cnt;
      tick();
      inject_val = 16'sh1234;
      inject_done = 1'b1;
      repeat (8) sample();
      checks++; if (ad_cnt !== na || bd_cnt !== nb) begin errors++; $display("FAIL rstmid_done: got %0d/%0d pulses want 0/0", ad_cnt - na, bd_cnt - nb); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
      checks++; if (bus.a_result !== 16'sd0) begin errors++; $display("FAIL rstmid_result: got %h want 0000", bus.a_result); end
      checks++; if (mv_cnt !== nm) begin errors++; $display("FAIL rstmid_reissue: got %0d mul_valid want 0", mv_cnt - nm); end
      resp_en = 1'b1;
   endtask

   task automatic test_timeout();
      int na;
      bit ok;
      do_reset();
      resp_en = 1'b0;
      na = ad_cnt;
      tick();
      bus.a_valid = 1'b1; bus.a_mc = 8'sd5; bus.a_mp = 8'sd9;
      wait_mv(10, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_issue: got no mul_valid within 10 cycles"); end
      tick();
      bus.a_valid = 1'b0;
`ifdef MULT_SCHED_TIMEOUT_EN
      wait_a_done(30, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_done: got no a_done within 30 cycles"); end
      checks++; if (ad_cyc !== mv_cyc + 16) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", ad_cyc, mv_cyc + 16); end
      checks++; if (bus.a_err !== 1'b1 || bus.a_result !== 16'sd0) begin
         errors++; $display("FAIL tmo_abort: got err=%b res=%h want err=1 res=0000", bus.a_err, bus.a_result);
      end
      do_reset();
      resp_en = 1'b1; resp_rand = 1'b0; resp_lat = 15;
      tick();
      bus.a_valid = 1'b1; bus.a_mc = -8'sd6; bus.a_mp = 8'sd11;
      wait_mv(10, ok);
      tick();
      bus.a_valid = 1'b0;
      wait_a_done(30, ok);
      checks++; if (ok !== 1'b1 || ad_cyc !== mv_cyc + 16) begin errors++; $display("FAIL tmo_tie_latency: got %0d want %0d", ad_cyc, mv_cyc + 16); end
      checks++; if (bus.a_err !== 1'b0 || bus.a_result !== -16'sd66) begin
         errors++; $display("FAIL tmo_tie_result: got err=%b res=%h want err=0 res=ffbe", bus.a_err, bus.a_result);
      end
      resp_lat = 8;
`else
      repeat (40) sample();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL tmo_off_busy: got %b want 1", bus.busy); end
      checks++; if (ad_cnt !== na || bus.a_err !== 1'b0) begin errors++; $display("FAIL tmo_off_done: got %0d pulses err=%b want 0 err=0", ad_cnt - na, bus.a_err); end
      do_reset();
      sample();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_off_reset: got busy=%b want 0", bus.busy); end
      resp_en = 1'b1;
`endif
   endtask

   initial begin
      test_reset();
      test_a_alone();
      test_both_valid();
      test_back_to_back();
      test_idle_done();
      test_reset_mid();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15, is the number of WAIT cycles without mul_done before abort; legal range 2..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a_valid/b_valid  input  1  requester A/B has an operand pair pending.
REQ-005 a_ready/b_ready  output  1  scheduler accepts that requester's pair this cycle.
REQ-006 a_mc, a_mp / b_mc, b_mp  input  8 each  signed multiplicand/multiplier per requester.
REQ-007 a_done/b_done  output  1  one-cycle completion pulse to that requester.
REQ-008 a_result/b_result  output  16  signed product; held until that requester's next completion.
REQ-009 a_err/b_err  output  1  set with done on timeout abort; held like result.
REQ-010 mul_valid  output  1  one-cycle start pulse to the shared multiplier.
REQ-011 mul_mc, mul_mp  output  8 each  latched operands; stable from ISSUE until leaving WAIT.
REQ-012 mul_done  input  1  multiplier completion strobe; mul_result  input  16  its signed product.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT, DELIVER; one-hot or binary is implementer's choice.
REQ-015 IDLE: ready asserted combinationally only for the granted requester; never both readies high.
REQ-016 Grant: if only one valid, grant it; if both, grant the one not served last (round-robin pointer).
REQ-017 Handshake valid&ready in IDLE latches operands and requester ID, flips pointer to the other requester, goes to ISSUE next cycle.
REQ-018 ISSUE: mul_valid=1 exactly one cycle, then WAIT.
REQ-019 WAIT: on mul_done=1, capture mul_result into the owning requester's result register, go DELIVER.
REQ-020 mul_done outside WAIT is ignored.
REQ-021 DELIVER: owner's done=1 for exactly one cycle, then IDLE; a new handshake is possible the cycle after DELIVER.
REQ-022 Latency: handshake at cycle T -> mul_valid at T+1; mul_done at cycle D -> done at D+1 with result valid.
REQ-023 The non-owner's result, err and done are unchanged during another requester's transaction.
REQ-024 Operands are passed to the multiplier unmodified; product is two's-complement 16-bit, no truncation or saturation.
REQ-025 A requester dropping valid after handshake has no effect on the in-flight transaction.

Reset
REQ-026 While rst=1 at a clock edge: state=IDLE, pointer favours A, mul_valid=0, all done=0, all err=0, all results=0, mul_mc=mul_mp=0, timeout counter=0.
REQ-027 Reset mid-transaction (ISSUE/WAIT/DELIVER) aborts it with no done pulse; a later stale mul_done is ignored per REQ-020.

Configuration
REQ-028 Macro MULT_SCHED_TIMEOUT_EN defined: WAIT counts cycles; on reaching TIMEOUT_CYC without mul_done, go DELIVER with owner result=0, err=1.
REQ-029 mul_done arriving in the same cycle as the counter reaching TIMEOUT_CYC wins: normal completion, err=0.
REQ-030 Macro undefined: no counter synthesized, WAIT waits indefinitely, a_err/b_err tied 0.

Structure
REQ-031 Package mult_pkg holds OP_W=8, RES_W=16, the state enum type and the requester-ID type.
REQ-032 Round-robin grant logic is a sub-module mult_rr_arb (inputs two valids plus pointer, outputs one-hot grant); all other logic stays in mult_sched.

Verification
REQ-033 A alone: a_mc=7, a_mp=-3, model mul_done 8 cycles after mul_valid -> a_done one cycle later, a_result=0xFFEB, b_done never pulses.
REQ-034 A and B valid together right after reset: A served first, then B; B's mul_valid occurs 1 cycle after A's DELIVER plus 1 handshake cycle.
REQ-035 A and B held valid continuously for 4 transactions -> grant order A,B,A,B; b_result=-128*-128=0x4000 retained across A's completions.
REQ-036 rst pulsed during WAIT, then mul_done arrives -> no done pulse, busy=0, state IDLE.
REQ-037 With MULT_SCHED_TIMEOUT_EN, TIMEOUT_CYC=15, mul_done never driven -> owner done and err both high 16 cycles after mul_valid, result=0; without the macro, busy stays 1.
REQ-038 mul_done pulsed while IDLE with no requests -> no outputs change.
